// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial signed subtractor.
// Flag word layout is {N,Z,V,C}, matching the adder post-processor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/fsub_cell.sv
// Combinational full-subtractor cell: d = a - b - br_in, with borrow-out.
module fsub_cell (
  input  logic a,
  input  logic b,
  input  logic br_in,
  output logic d,
  output logic br_out
);

  assign d      = a ^ b ^ br_in;
  assign br_out = (~a & b) | (~(a ^ b) & br_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial signed subtractor, LSB first, one bit per clock, behind valid/ready.
// Produces a sign-extended WIDTH+1 result so the difference never wraps.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic             BorrowIn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   Result,
  output logic [3:0]       Flags
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] MSB_BIT  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] SIGN_BIT = CW'(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             br_reg, br_next;
  logic             c_reg, c_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH:0]   sh_reg, sh_next;
  logic [WIDTH:0]   result_reg, result_next;
  logic [3:0]       flags_reg, flags_next;
  logic             init_reg;

  logic [WIDTH:0]   a_ext, b_ext, diff_full;
  logic             d_bit, br_out;

  // Sign-extended operands let bit WIDTH reuse the same indexing as the data bits.
  assign a_ext = {a_reg[WIDTH-1], a_reg};
  assign b_ext = {b_reg[WIDTH-1], b_reg};

  fsub_cell u_cell (
    .a      (a_ext[cnt_reg]),
    .b      (b_ext[cnt_reg]),
    .br_in  (br_reg),
    .d      (d_bit),
    .br_out (br_out)
  );

  assign diff_full = {d_bit, sh_reg[WIDTH:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      br_reg     <= 1'b0;
      c_reg      <= 1'b0;
      cnt_reg    <= '0;
      sh_reg     <= '0;
      result_reg <= '0;
      flags_reg  <= '0;
      init_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      br_reg     <= br_next;
      c_reg      <= c_next;
      cnt_reg    <= cnt_next;
      sh_reg     <= sh_next;
      result_reg <= result_next;
      flags_reg  <= flags_next;
      init_reg   <= 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    br_next     = br_reg;
    c_next      = c_reg;
    cnt_next    = cnt_reg;
    sh_next     = sh_reg;
    result_next = result_reg;
    flags_next  = flags_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid && init_reg) begin
          a_next     = Ain;
          b_next     = Bin;
          br_next    = BorrowIn;
          cnt_next   = '0;
          state_next = CALC;
        end
      end
      CALC: begin
        sh_next  = diff_full;
        br_next  = br_out;
        cnt_next = cnt_reg + CW'(1);
        // Borrow out of the top operand bit is the unsigned borrow.
        if (cnt_reg == MSB_BIT) begin
          c_next = br_out;
        end
        if (cnt_reg == SIGN_BIT) begin
          state_next         = DONE;
          result_next        = diff_full;
          flags_next[FLAG_N] = diff_full[WIDTH];
          flags_next[FLAG_Z] = ~|diff_full;
          flags_next[FLAG_V] = diff_full[WIDTH] ^ diff_full[WIDTH-1];
          flags_next[FLAG_C] = c_reg;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE) && init_reg;
  assign out_valid = (state_reg == DONE);
  assign Result    = result_reg;
  assign Flags     = flags_reg;

endmodule
